// File: rtl/cas_prefetch_buffer.sv
// Cassette image prefetch FIFO between the DDR3 CAS read port and the tape player.
// Optional build macro CAS_PREFETCH_STATS_EN adds the underrun_cnt statistics output.
module cas_prefetch_buffer #(
    parameter logic [27:0] BASE_ADDR = 28'h1400000,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned LVL_W     = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rewind,
    input  logic [27:0]      cas_size,
    input  logic             ddr3_grant,
    output logic [27:0]      ddr3_addr,
    output logic             ddr3_rd,
    input  logic [7:0]       ddr3_dout,
    input  logic             ddr3_ready,
    input  logic             rd_req,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             eof,
    output logic [LVL_W-1:0] level
`ifdef CAS_PREFETCH_STATS_EN
    ,
    output logic [15:0]      underrun_cnt
`endif
);

    localparam int unsigned PTR_W  = LVL_W - 1;
    localparam int unsigned ADDR_W = 28;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ISSUE     = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] WAIT_DATA = 3'd3;
    localparam logic [2:0] DRAIN     = 3'd4;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] fetched;
    logic [ADDR_W-1:0] delivered;
    logic [ADDR_W-1:0] size_q;
    logic              size_vld;
    logic              pending;
    logic              busy_cnt;
    logic              busy_done;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [7:0]        mem [DEPTH];

    logic fifo_empty;
    logic req_ok;
    logic push;
    logic pop;
    logic bypass;
    logic wr_en;
    logic deliver;
    logic issue_ok;

    // Consumer/producer handshakes; rewind suppresses both sides for its cycle
    always_comb begin
        fifo_empty = (level == LVL_W'(0));
        req_ok     = rd_req & ~eof & ~rewind;
        push       = (state == WAIT_DATA) & ddr3_ready & ~rewind;
        pop        = req_ok & ~fifo_empty;
        bypass     = push & fifo_empty & (req_ok | pending);
        wr_en      = push & ~bypass;
        deliver    = pop | bypass;
        issue_ok   = size_vld & ddr3_grant & ddr3_ready
                   & (fetched < size_q) & (level < LVL_W'(DEPTH));
    end

    // Fetch FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Fetch FSM next state; an issued read always runs to completion before IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!rewind && issue_ok) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = rewind ? DRAIN : WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (rewind) begin
                    state_nxt = DRAIN;
                end else if (!ddr3_ready || busy_cnt) begin
                    state_nxt = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (rewind) begin
                    state_nxt = DRAIN;
                end else if (ddr3_ready) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (busy_done && ddr3_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Tracks whether the in-flight read has passed its busy phase (needed by DRAIN)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_cnt  <= 1'b0;
            busy_done <= 1'b0;
        end else if (state == ISSUE) begin
            busy_cnt  <= 1'b0;
            busy_done <= 1'b0;
        end else if (state == WAIT_DATA) begin
            busy_done <= 1'b1;
        end else if ((state == WAIT_BUSY || state == DRAIN) && !busy_done) begin
            busy_cnt <= 1'b1;
            if (!ddr3_ready || busy_cnt) begin
                busy_done <= 1'b1;
            end
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= ddr3_dout;
        end
    end

    // Counters, pointers and consumer-side outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ddr3_addr <= BASE_ADDR;
            ddr3_rd   <= 1'b0;
            rd_data   <= 8'hFF;
            rd_valid  <= 1'b0;
            eof       <= 1'b0;
            level     <= LVL_W'(0);
            fetched   <= ADDR_W'(0);
            delivered <= ADDR_W'(0);
            size_q    <= ADDR_W'(0);
            size_vld  <= 1'b0;
            pending   <= 1'b0;
            wr_ptr    <= PTR_W'(0);
            rd_ptr    <= PTR_W'(0);
        end else begin
            ddr3_rd  <= (state_nxt == ISSUE);
            rd_valid <= 1'b0;
            if (rewind) begin
                ddr3_addr <= BASE_ADDR;
                eof       <= (cas_size == ADDR_W'(0));
                level     <= LVL_W'(0);
                fetched   <= ADDR_W'(0);
                delivered <= ADDR_W'(0);
                size_q    <= cas_size;
                size_vld  <= 1'b1;
                pending   <= 1'b0;
                wr_ptr    <= PTR_W'(0);
                rd_ptr    <= PTR_W'(0);
            end else begin
                // First cycle after reset release samples the image size
                if (!size_vld) begin
                    size_vld <= 1'b1;
                    size_q   <= cas_size;
                    eof      <= (cas_size == ADDR_W'(0));
                end
                if (push) begin
                    fetched   <= fetched + ADDR_W'(1);
                    ddr3_addr <= ddr3_addr + ADDR_W'(1);
                end
                if (wr_en) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr  <= rd_ptr + PTR_W'(1);
                    rd_data <= mem[rd_ptr];
                end
                // A waiting consumer takes the arriving byte straight from DDR3
                if (bypass) begin
                    rd_data <= ddr3_dout;
                end
                if (deliver) begin
                    rd_valid  <= 1'b1;
                    delivered <= delivered + ADDR_W'(1);
                    eof       <= ((delivered + ADDR_W'(1)) == size_q);
                end
                if (bypass) begin
                    pending <= 1'b0;
                end else if (req_ok && fifo_empty) begin
                    pending <= 1'b1;
                end
                case ({wr_en, pop})
                    2'b10:   level <= level + LVL_W'(1);
                    2'b01:   level <= level - LVL_W'(1);
                    default: level <= level;
                endcase
            end
        end
    end

`ifdef CAS_PREFETCH_STATS_EN
    // Saturating count of requests that found the FIFO empty
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_cnt <= 16'h0000;
        end else if (rewind) begin
            underrun_cnt <= 16'h0000;
        end else if (req_ok && fifo_empty && underrun_cnt != 16'hFFFF) begin
            underrun_cnt <= underrun_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_cas_prefetch_buffer.sv
// Directed testbench for cas_prefetch_buffer with a 3-cycle-latency DDR3 read model.
module tb_cas_prefetch_buffer;

    localparam logic [27:0] BASE = 28'h1400000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rewind;
    logic [27:0] cas_size;
    logic        ddr3_grant;
    logic [27:0] ddr3_addr;
    logic        ddr3_rd;
    logic [7:0]  ddr3_dout;
    logic        ddr3_ready;
    logic        rd_req;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        eof;
    logic [4:0]  level;
`ifdef CAS_PREFETCH_STATS_EN
    logic [15:0] underrun_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cas_prefetch_buffer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rewind     (rewind),
        .cas_size   (cas_size),
        .ddr3_grant (ddr3_grant),
        .ddr3_addr  (ddr3_addr),
        .ddr3_rd    (ddr3_rd),
        .ddr3_dout  (ddr3_dout),
        .ddr3_ready (ddr3_ready),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .eof        (eof),
        .level      (level)
`ifdef CAS_PREFETCH_STATS_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    // DDR3 model: ready drops after a read strobe, data = addr[7:0] three cycles later
    logic [27:0] ddr_addr_q;
    int          ddr_cnt;
    time         t_ready;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ddr3_ready <= 1'b1;
            ddr3_dout  <= 8'h00;
            ddr_cnt    <= 0;
        end else if (ddr_cnt != 0) begin
            ddr_cnt <= ddr_cnt - 1;
            if (ddr_cnt == 1) begin
                ddr3_ready <= 1'b1;
                ddr3_dout  <= ddr_addr_q[7:0];
                t_ready    = $time;
            end
        end else if (ddr3_rd) begin
            ddr3_ready <= 1'b0;
            ddr_addr_q <= ddr3_addr;
            ddr_cnt    <= 3;
        end
    end

    // Read-strobe log and rd_valid pulse counter
    logic [27:0] rd_log [64];
    int          rd_cnt = 0;
    int          rv_cnt = 0;
    always @(posedge clk) begin
        if (ddr3_rd) begin
            rd_log[rd_cnt % 64] <= ddr3_addr;
            rd_cnt <= rd_cnt + 1;
        end
        if (rd_valid) begin
            rv_cnt <= rv_cnt + 1;
        end
    end

    task automatic pulse_rewind(input logic [27:0] sz);
        @(negedge clk);
        cas_size = sz;
        rewind   = 1'b1;
        @(negedge clk);
        rewind   = 1'b0;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        rewind     = 1'b0;
        rd_req     = 1'b0;
        ddr3_grant = 1'b1;
        cas_size   = 28'd4;
        repeat (2) @(negedge clk);
        checks++; if (ddr3_addr !== BASE) begin failures++; $display("FAIL reset_addr got=%h exp=%h", ddr3_addr, BASE); end
        checks++; if (ddr3_rd !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b exp=0", ddr3_rd); end
        checks++; if (rd_data !== 8'hFF) begin failures++; $display("FAIL reset_rd_data got=%h exp=ff", rd_data); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        checks++; if (eof !== 1'b0) begin failures++; $display("FAIL reset_eof got=%b exp=0", eof); end
        checks++; if (level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        reset_n = 1'b1;
    endtask

    task automatic test_fill_small();
        for (int i = 0; i < 200 && level !== 5'd4; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        checks++; if (level !== 5'd4) begin failures++; $display("FAIL fill_level got=%0d exp=4", level); end
        checks++; if (rd_cnt !== 4) begin failures++; $display("FAIL fill_rd_count got=%0d exp=4", rd_cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_log[i] !== BASE + 28'(i)) begin
                failures++; $display("FAIL fill_addr%0d got=%h exp=%h", i, rd_log[i], BASE + 28'(i));
            end
        end
    endtask

    task automatic test_consume();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rd_req = 1'b1;
            @(negedge clk);
            rd_req = 1'b0;
            checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL consume_valid%0d got=%b exp=1", i, rd_valid); end
            checks++; if (rd_data !== 8'(i)) begin failures++; $display("FAIL consume_data%0d got=%h exp=%h", i, rd_data, 8'(i)); end
            repeat (8) @(negedge clk);
        end
        checks++; if (eof !== 1'b1) begin failures++; $display("FAIL consume_eof got=%b exp=1", eof); end
        @(negedge clk);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL consume_after_eof got=%b exp=0", rd_valid); end
        checks++; if (rd_cnt !== 4) begin failures++; $display("FAIL consume_no_fetch got=%0d exp=4", rd_cnt); end
    endtask

    task automatic test_full();
        int r0;
        r0 = rd_cnt;
        pulse_rewind(28'd100);
        for (int i = 0; i < 400 && level !== 5'd16; i++) @(negedge clk);
        repeat (30) @(negedge clk);
        checks++; if (level !== 5'd16) begin failures++; $display("FAIL full_level got=%0d exp=16", level); end
        checks++; if (rd_cnt - r0 !== 16) begin failures++; $display("FAIL full_rd_count got=%0d exp=16", rd_cnt - r0); end
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        checks++; if (rd_data !== 8'h00 || rd_valid !== 1'b1) begin failures++; $display("FAIL full_pop got=%h/%b exp=00/1", rd_data, rd_valid); end
        repeat (30) @(negedge clk);
        checks++; if (rd_cnt - r0 !== 17) begin failures++; $display("FAIL full_refetch_count got=%0d exp=17", rd_cnt - r0); end
        checks++; if (level !== 5'd16) begin failures++; $display("FAIL full_level_back got=%0d exp=16", level); end
        checks++; if (rd_log[(rd_cnt - 1) % 64] !== BASE + 28'h10) begin failures++; $display("FAIL full_refetch_addr got=%h exp=%h", rd_log[(rd_cnt - 1) % 64], BASE + 28'h10); end
    endtask

    task automatic test_grant();
        int r0;
        int v0;
        bit seen;
        @(negedge clk);
        ddr3_grant = 1'b0;
        pulse_rewind(28'd4);
        repeat (5) @(negedge clk);
        checks++; if (level !== 5'd0) begin failures++; $display("FAIL grant_level got=%0d exp=0", level); end
        r0 = rd_cnt;
        v0 = rv_cnt;
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (rv_cnt !== v0) begin failures++; $display("FAIL grant_no_valid got=%0d exp=%0d", rv_cnt, v0); end
        checks++; if (rd_cnt !== r0) begin failures++; $display("FAIL grant_no_rd got=%0d exp=%0d", rd_cnt, r0); end
        ddr3_grant = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = rd_valid;
        end
        checks++; if (!seen) begin failures++; $display("FAIL grant_valid_timeout got=0 exp=1"); end
        checks++; if ($time - t_ready !== 15) begin failures++; $display("FAIL grant_latency got=%0t exp=15", $time - t_ready); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL grant_data got=%h exp=00", rd_data); end
`ifdef CAS_PREFETCH_STATS_EN
        checks++; if (underrun_cnt !== 16'd1) begin failures++; $display("FAIL grant_underrun got=%0d exp=1", underrun_cnt); end
`endif
    endtask

    task automatic test_rewind_drain();
        int r0;
        int v0;
        bit seen;
        pulse_rewind(28'd100);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            seen = ddr3_rd && (ddr3_addr == BASE + 28'h7);
        end
        checks++; if (!seen) begin failures++; $display("FAIL drain_issue7_timeout got=0 exp=1"); end
        @(negedge clk);
        rewind = 1'b1;
        @(negedge clk);
        rewind = 1'b0;
        r0 = rd_cnt;
        v0 = rv_cnt;
        checks++; if (level !== 5'd0) begin failures++; $display("FAIL drain_level got=%0d exp=0", level); end
        for (int i = 0; i < 50 && rd_cnt == r0; i++) @(negedge clk);
        checks++; if (rd_log[r0 % 64] !== BASE) begin failures++; $display("FAIL drain_restart_addr got=%h exp=%h", rd_log[r0 % 64], BASE); end
        checks++; if (rv_cnt !== v0) begin failures++; $display("FAIL drain_valid got=%0d exp=%0d", rv_cnt, v0); end
        for (int i = 0; i < 50 && level == 5'd0; i++) @(negedge clk);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin failures++; $display("FAIL drain_first_data got=%h/%b exp=00/1", rd_data, rd_valid); end
    endtask

    task automatic test_async_reset();
        bit seen;
        int r0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = ddr3_rd;
        end
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (ddr3_addr !== BASE) begin failures++; $display("FAIL areset_addr got=%h exp=%h", ddr3_addr, BASE); end
        checks++; if (ddr3_rd !== 1'b0) begin failures++; $display("FAIL areset_rd got=%b exp=0", ddr3_rd); end
        checks++; if (rd_data !== 8'hFF) begin failures++; $display("FAIL areset_rd_data got=%h exp=ff", rd_data); end
        checks++; if (rd_valid !== 1'b0 || eof !== 1'b0) begin failures++; $display("FAIL areset_valid_eof got=%b%b exp=00", rd_valid, eof); end
        checks++; if (level !== 5'd0) begin failures++; $display("FAIL areset_level got=%0d exp=0", level); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        r0 = rd_cnt;
        for (int i = 0; i < 50 && rd_cnt == r0; i++) @(negedge clk);
        checks++; if (rd_cnt == r0 || rd_log[r0 % 64] !== BASE) begin failures++; $display("FAIL areset_restart_addr got=%h exp=%h", rd_log[r0 % 64], BASE); end
    endtask

    task automatic test_zero_size();
        int r0;
        pulse_rewind(28'd0);
        r0 = rd_cnt;
        checks++; if (eof !== 1'b1) begin failures++; $display("FAIL zero_eof got=%b exp=1", eof); end
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL zero_valid got=%b exp=0", rd_valid); end
        repeat (30) @(negedge clk);
        checks++; if (rd_cnt !== r0 || level !== 5'd0) begin failures++; $display("FAIL zero_no_fetch got=%0d/%0d exp=%0d/0", rd_cnt, level, r0); end
    endtask

    initial begin
        test_reset();
        test_fill_small();
        test_consume();
        test_full();
        test_grant();
        test_rewind_drain();
        test_async_reset();
        test_zero_size();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
